// File: rtl/mmio_uart_hub.sv
// mmio_uart_hub: registered MMIO slave fanning out to NUM_CH uartwriter channels.
// Channel c decodes at 0xFF-4c (TX), 0xFE-4c (RX data), 0xFD-4c (RX present), 0xFC-4c (STATUS).
module mmio_uart_hub #(
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_CH         = 4,
  parameter int TX_FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic [31:0]                         i_mmio_addr,
  input  logic [DATA_WIDTH-1:0]               i_mmio_data,
  input  logic                                i_mmio_wr_valid,
  output logic                                o_mmio_wr_ready,
  output logic [DATA_WIDTH-1:0]               o_mmio_data,
  output logic                                o_mmio_rd_valid,
  input  logic                                i_mmio_rd_ready,
  output logic [NUM_CH*8-1:0]                 o_tx_data,
  output logic [NUM_CH-1:0]                   o_tx_valid,
  input  logic [NUM_CH-1:0]                   i_tx_ready,
  input  logic [NUM_CH*(TX_FIFO_DEPTH+1)-1:0] i_tx_free,
  input  logic [NUM_CH*8-1:0]                 i_rx_data,
  input  logic [NUM_CH-1:0]                   i_rx_valid,
  output logic [NUM_CH-1:0]                   o_rx_ready,
  input  logic [NUM_CH-1:0]                   i_rx_present,
  output logic                                o_irq,
  output logic                                o_timeout
);

  localparam int FW = TX_FIFO_DEPTH + 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, RD_FAST, WAIT_TX, WAIT_RX, RESP, GAP} state_t;
  typedef enum logic [1:0] {REG_TX, REG_RXD, REG_RXP, REG_STAT} reg_t;

  state_t state, state_nx;

  logic [7:0]  addr_inv;
  logic [5:0]  acc_ch;
  reg_t        acc_reg;
  logic        accept, acc_mapped, acc_tx_wr, acc_rx_rd;

  logic [5:0]            ch_q;
  reg_t                  reg_q;
  logic                  wr_q;
  logic                  mapped_q;
  logic [2:0]            ctrl_q;
  logic [DATA_WIDTH-1:0] resp_q;
  logic [CW-1:0]         to_cnt;
  logic                  to_last, to_fire, timeout_q;
  logic [NUM_CH*8-1:0]   tx_data_q;
  logic [NUM_CH-1:0]     rx_ie, err_ie, sticky_to;

  logic          sel_tx_ready, sel_rx_valid, sel_rx_present;
  logic          sel_rx_ie, sel_err_ie, sel_sticky;
  logic [7:0]    sel_rx_data;
  logic [FW-1:0] sel_tx_free;
  logic [4:0]    status_word;
  logic          bits_unused;

  // Offsets count down from 0xFF, so inverting the low byte yields {channel, register}.
  assign addr_inv   = ~i_mmio_addr[7:0];
  assign acc_ch     = addr_inv[7:2];
  assign acc_reg    = reg_t'(addr_inv[1:0]);
  assign acc_mapped = int'(acc_ch) < NUM_CH;
  assign accept     = i_mmio_wr_valid | i_mmio_rd_ready;
  assign acc_tx_wr  = i_mmio_wr_valid & acc_mapped & (acc_reg == REG_TX);
  assign acc_rx_rd  = ~i_mmio_wr_valid & acc_mapped & (acc_reg == REG_RXD);
  assign mapped_q   = int'(ch_q) < NUM_CH;
  assign bits_unused = ^{i_mmio_addr[31:8], i_mmio_data[DATA_WIDTH-1:8]};

  // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
  always_comb begin
    sel_tx_ready   = 1'b0;
    sel_rx_valid   = 1'b0;
    sel_rx_present = 1'b0;
    sel_rx_ie      = 1'b0;
    sel_err_ie     = 1'b0;
    sel_sticky     = 1'b0;
    sel_rx_data    = '0;
    sel_tx_free    = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_q == 6'(c)) begin
        sel_tx_ready   = i_tx_ready[c];
        sel_rx_valid   = i_rx_valid[c];
        sel_rx_present = i_rx_present[c];
        sel_rx_ie      = rx_ie[c];
        sel_err_ie     = err_ie[c];
        sel_sticky     = sticky_to[c];
        sel_rx_data    = i_rx_data[8*c +: 8];
        sel_tx_free    = i_tx_free[FW*c +: FW];
      end
    end
  end

  assign status_word = {sel_err_ie, sel_rx_ie, sel_sticky, (sel_tx_free == '0), sel_rx_present};
  assign to_last     = (to_cnt == TO_LAST);
  // A handshake on the final wait cycle takes priority over the timeout.
  assign to_fire     = to_last & (((state == WAIT_TX) & ~sel_tx_ready) |
                                  ((state == WAIT_RX) & ~sel_rx_valid));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (acc_tx_wr)      state_nx = WAIT_TX;
          else if (acc_rx_rd) state_nx = WAIT_RX;
          else                state_nx = RD_FAST;
        end
      end
      RD_FAST: state_nx = RESP;
      WAIT_TX: if (sel_tx_ready || to_last) state_nx = RESP;
      WAIT_RX: if (sel_rx_valid || to_last) state_nx = RESP;
      RESP:    state_nx = GAP;
      GAP:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ch_q      <= '0;
      reg_q     <= REG_TX;
      wr_q      <= 1'b0;
      ctrl_q    <= '0;
      resp_q    <= '0;
      to_cnt    <= '0;
      timeout_q <= 1'b0;
      tx_data_q <= '0;
      rx_ie     <= '0;
      err_ie    <= '0;
      sticky_to <= '0;
    end else begin
      timeout_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            ch_q   <= acc_ch;
            reg_q  <= acc_reg;
            wr_q   <= i_mmio_wr_valid;
            ctrl_q <= i_mmio_data[4:2];
            resp_q <= '0;
            to_cnt <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
              if (acc_tx_wr && acc_ch == 6'(c)) tx_data_q[8*c +: 8] <= i_mmio_data[7:0];
            end
          end
        end
        RD_FAST: begin
          if (!wr_q && mapped_q) begin
            case (reg_q)
              REG_TX:   resp_q <= DATA_WIDTH'(sel_tx_free);
              REG_RXP:  resp_q <= DATA_WIDTH'(sel_rx_present);
              REG_STAT: resp_q <= DATA_WIDTH'(status_word);
              default:  resp_q <= '0;
            endcase
          end else if (wr_q && mapped_q && reg_q == REG_STAT) begin
            for (int c = 0; c < NUM_CH; c++) begin
              if (ch_q == 6'(c)) begin
                rx_ie[c]  <= ctrl_q[1];
                err_ie[c] <= ctrl_q[2];
                if (ctrl_q[0]) sticky_to[c] <= 1'b0;
              end
            end
          end
        end
        WAIT_TX, WAIT_RX: begin
          if (state == WAIT_RX && sel_rx_valid) begin
            resp_q <= DATA_WIDTH'(sel_rx_data);
          end else if (to_fire) begin
            timeout_q <= 1'b1;
            if (state == WAIT_RX) resp_q <= DATA_WIDTH'(9'h100);
            for (int c = 0; c < NUM_CH; c++) begin
              if (ch_q == 6'(c)) sticky_to[c] <= 1'b1;
            end
          end else if (!(state == WAIT_TX && sel_tx_ready)) begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Strobes decode straight from the state register so an async reset drops them at once.
  always_comb begin
    o_tx_valid = '0;
    o_rx_ready = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      o_tx_valid[c] = (state == WAIT_TX) && (ch_q == 6'(c));
      o_rx_ready[c] = (state == WAIT_RX) && (ch_q == 6'(c));
    end
  end

  assign o_mmio_wr_ready = (state == RESP) & wr_q;
  assign o_mmio_rd_valid = (state == RESP) & ~wr_q;
  assign o_mmio_data     = o_mmio_rd_valid ? resp_q : '0;
  assign o_tx_data       = tx_data_q;
  assign o_timeout       = timeout_q;
  assign o_irq           = |((rx_ie & i_rx_present) | (err_ie & sticky_to));

endmodule

// File: tb/tb_mmio_uart_hub.sv
// Directed bench for mmio_uart_hub with NUM_CH=2 and TIMEOUT_CYCLES=16.
// Expected values are hand-computed from the register map and FSM timing.
module tb_mmio_uart_hub;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] mmio_addr = '0;
  logic [31:0] mmio_wdata = '0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [31:0] rdata;
  logic        rd_valid;
  logic        rd_ready = 1'b0;
  logic [15:0] tx_data;
  logic [1:0]  tx_valid;
  logic [1:0]  tx_ready = '0;
  logic [9:0]  tx_free = {5'd4, 5'd4};
  logic [15:0] rx_data = '0;
  logic [1:0]  rx_valid = '0;
  logic [1:0]  rx_ready;
  logic [1:0]  rx_present = '0;
  logic        irq;
  logic        timeout;

  int checks = 0;
  int errors = 0;

  mmio_uart_hub #(
    .DATA_WIDTH(32), .NUM_CH(2), .TX_FIFO_DEPTH(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_mmio_addr(mmio_addr), .i_mmio_data(mmio_wdata),
    .i_mmio_wr_valid(wr_valid), .o_mmio_wr_ready(wr_ready),
    .o_mmio_data(rdata), .o_mmio_rd_valid(rd_valid), .i_mmio_rd_ready(rd_ready),
    .o_tx_data(tx_data), .o_tx_valid(tx_valid), .i_tx_ready(tx_ready), .i_tx_free(tx_free),
    .i_rx_data(rx_data), .i_rx_valid(rx_valid), .o_rx_ready(rx_ready),
    .i_rx_present(rx_present), .o_irq(irq), .o_timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mmio_read(input logic [31:0] addr, output logic [31:0] data, output int lat);
    bit seen = 1'b0;
    mmio_addr = addr;
    rd_ready  = 1'b1;
    data = '0;
    lat  = 0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      tick();
      if (rd_valid) begin
        seen = 1'b1;
        data = rdata;
        lat  = i;
      end
    end
    rd_ready = 1'b0;
    check("rd_response_seen", 32'(seen), 32'd1);
    tick();
    tick();
  endtask

  task automatic mmio_write(input logic [31:0] addr, input logic [31:0] data, output int lat);
    bit seen = 1'b0;
    mmio_addr  = addr;
    mmio_wdata = data;
    wr_valid   = 1'b1;
    lat = 0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      tick();
      if (wr_ready) begin
        seen = 1'b1;
        lat  = i;
      end
    end
    wr_valid = 1'b0;
    check("wr_ack_seen", 32'(seen), 32'd1);
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int lat;

    #23 rst = 1'b0;
    tick();
    check("rst_tx_valid", 32'(tx_valid), 32'h0);
    check("rst_rx_ready", 32'(rx_ready), 32'h0);
    check("rst_wr_ready", 32'(wr_ready), 32'h0);
    check("rst_rd_valid", 32'(rd_valid), 32'h0);
    check("rst_irq",      32'(irq),      32'h0);
    check("rst_timeout",  32'(timeout),  32'h0);
    check("rst_tx_data",  32'(tx_data),  32'h0);

    // TX write to channel 0, ready arrives on the third wait cycle.
    mmio_addr = 32'hFF; mmio_wdata = 32'h41; wr_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("tx_valid_wait", 32'(tx_valid), 32'h1);
      check("tx_byte",       32'(tx_data[7:0]), 32'h41);
      check("tx_no_ack",     32'(wr_ready), 32'h0);
      if (i == 3) tx_ready = 2'b01;
    end
    tick();
    tx_ready = 2'b00;
    check("tx_valid_drop", 32'(tx_valid), 32'h0);
    check("tx_ack",        32'(wr_ready), 32'h1);
    wr_valid = 1'b0;
    tick();
    check("tx_ack_once",   32'(wr_ready), 32'h0);
    tick();

    // RX read on channel 1, data arrives on the fifth wait cycle.
    mmio_addr = 32'hFA; rd_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("rx_ready_wait", 32'(rx_ready), 32'h2);
      check("rx_no_resp",    32'(rd_valid), 32'h0);
      if (i == 5) begin rx_valid = 2'b10; rx_data = 16'h5A00; end
    end
    tick();
    rx_valid = 2'b00;
    check("rx_resp_valid", 32'(rd_valid), 32'h1);
    check("rx_resp_data",  rdata,         32'h5A);
    check("rx_ready_drop", 32'(rx_ready), 32'h0);
    rd_ready = 1'b0;
    tick();
    check("rx_resp_once",  32'(rd_valid), 32'h0);
    tick();

    // RX read on channel 0 with nothing arriving; request withdrawn early.
    mmio_addr = 32'hFE; rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      check("to_rx_ready", 32'(rx_ready), 32'h1);
      check("to_no_pulse", 32'(timeout),  32'h0);
      tick();
    end
    check("to_pulse",      32'(timeout),  32'h1);
    check("to_rd_valid",   32'(rd_valid), 32'h1);
    check("to_rd_data",    rdata,         32'h100);
    check("to_rx_drop",    32'(rx_ready), 32'h0);
    tick();
    check("to_pulse_end",  32'(timeout),  32'h0);
    tick();
    mmio_read(32'hFC, d, lat);
    check("status0_sticky", d, 32'h04);
    mmio_write(32'hFC, 32'h04, lat);
    check("status_wr_lat", 32'(lat), 32'd2);
    mmio_read(32'hFC, d, lat);
    check("status0_clear", d, 32'h00);

    // Channel 1 RX interrupt enable and status/free-count reads.
    mmio_write(32'hF8, 32'h08, lat);
    check("irq_idle", 32'(irq), 32'h0);
    rx_present = 2'b10;
    #1 check("irq_rx", 32'(irq), 32'h1);
    tx_free = {5'd0, 5'd4};
    mmio_read(32'hF8, d, lat);
    check("status1_full", d, 32'h0B);
    tx_free = {5'd3, 5'd4};
    mmio_read(32'hFB, d, lat);
    check("tx_free1", d, 32'h3);
    mmio_read(32'hF9, d, lat);
    check("rx_present1", d, 32'h1);
    mmio_read(32'hFD, d, lat);
    check("rx_present0", d, 32'h0);
    rx_present = 2'b00;
    #1 check("irq_clear", 32'(irq), 32'h0);

    // Error interrupt from a TX timeout on channel 0.
    mmio_write(32'hFC, 32'h10, lat);
    mmio_write(32'hFF, 32'h33, lat);
    check("tx_to_lat", 32'(lat), 32'd17);
    check("irq_err", 32'(irq), 32'h1);
    mmio_read(32'hFC, d, lat);
    check("status0_err", d, 32'h14);
    mmio_write(32'hFC, 32'h14, lat);
    check("irq_err_clear", 32'(irq), 32'h0);

    // Unmapped channel 3 read and write.
    mmio_read(32'hF3, d, lat);
    check("unmapped_data", d, 32'h0);
    check("unmapped_lat", 32'(lat), 32'd2);
    mmio_write(32'hF3, 32'hFF, lat);
    check("unmapped_wr_lat", 32'(lat), 32'd2);

    // Simultaneous write and read: write first, read after the gap.
    tx_ready = 2'b01;
    mmio_addr = 32'hFF; mmio_wdata = 32'h77; wr_valid = 1'b1; rd_ready = 1'b1;
    tick();
    check("both_tx_valid", 32'(tx_valid), 32'h1);
    tick();
    check("both_wr_ack", 32'(wr_ready), 32'h1);
    check("both_no_rd",  32'(rd_valid), 32'h0);
    wr_valid = 1'b0;
    tx_ready = 2'b00;
    tick();
    check("both_gap", 32'(rd_valid | wr_ready), 32'h0);
    tick();
    tick();
    tick();
    check("both_rd_valid", 32'(rd_valid), 32'h1);
    check("both_rd_data",  rdata, 32'h4);
    check("both_tx_byte",  32'(tx_data[7:0]), 32'h77);
    rd_ready = 1'b0;
    tick();
    tick();

    // Reset during a channel 1 TX wait.
    mmio_write(32'hF8, 32'h08, lat);
    mmio_addr = 32'hFB; mmio_wdata = 32'h99; wr_valid = 1'b1;
    tick();
    check("rst_pre_valid", 32'(tx_valid), 32'h2);
    #3 rst = 1'b1;
    #1 check("rst_async_drop", 32'(tx_valid), 32'h0);
    check("rst_no_ack", 32'(wr_ready), 32'h0);
    wr_valid = 1'b0;
    rx_present = 2'b10;
    @(posedge clk);
    #3 rst = 1'b0;
    tick();
    check("rst_tx_data_clr", 32'(tx_data), 32'h0);
    check("rst_irq_clr", 32'(irq), 32'h0);
    mmio_read(32'hF8, d, lat);
    check("post_rst_status", d, 32'h01);
    rx_present = 2'b00;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_uart_hub.md
Name: mmio_uart_hub

Overview:
- Multi-channel MMIO slave that replaces the single-UART combinational decode in the top level.
- Sits between the memmap MMIO port and NUM_CH uartwriter instances.
- Registers every transaction, stalls on TX/RX handshakes with a bounded timeout, and adds per-channel status/control with sticky error bits and a level interrupt.
- Channel 0 keeps the legacy offsets 0xFF/0xFE/0xFD.

Parameters:
- DATA_WIDTH, 32, MMIO data width; must be ≥ 9 and ≥ TX_FIFO_DEPTH+1.
- NUM_CH, 4, number of UART channels, 1..16.
- TX_FIFO_DEPTH, 4, matches uartwriter; free-count width is TX_FIFO_DEPTH+1.
- TIMEOUT_CYCLES, 1024, maximum wait for a channel handshake, ≥ 2.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous active-high reset
- i_mmio_addr  in  32  MMIO address; only [7:0] is decoded
- i_mmio_data  in  DATA_WIDTH  write data from memmap
- i_mmio_wr_valid  in  1  write request, held until acked
- o_mmio_wr_ready  out  1  one-cycle write ack
- o_mmio_data  out  DATA_WIDTH  read data, valid with o_mmio_rd_valid
- o_mmio_rd_valid  out  1  one-cycle read response
- i_mmio_rd_ready  in  1  read request, held until response
- o_tx_data  out  NUM_CH*8  per-channel TX byte; channel c at [8c+7:8c]
- o_tx_valid  out  NUM_CH  TX valid
- i_tx_ready  in  NUM_CH  TX ready
- i_tx_free  in  NUM_CH*(TX_FIFO_DEPTH+1)  TX FIFO free count
- i_rx_data  in  NUM_CH*8  RX byte
- i_rx_valid  in  NUM_CH  RX valid
- o_rx_ready  out  NUM_CH  RX ready
- i_rx_present  in  NUM_CH  RX byte present
- o_irq  out  1  OR over channels of (rx_ie & rx_present) | (err_ie & sticky_to)
- o_timeout  out  1  one-cycle pulse when any handshake times out

Behaviour:
- Decode:
  - a = ~i_mmio_addr[7:0]; ch = a[7:2]; reg = a[1:0].
  - reg 0 = TX, 1 = RX data, 2 = RX present, 3 = STATUS.
  - Channel c occupies 0xFF-4c .. 0xFC-4c.
  - ch ≥ NUM_CH is unmapped.
- Reset: all outputs 0, FSM IDLE, rx_ie = err_ie = sticky_to = 0 on every channel, timeout counter 0.
- FSM states: IDLE, RD_FAST, WAIT_TX, WAIT_RX, RESP, GAP.
- IDLE accept:
  - Write wins if i_mmio_wr_valid and i_mmio_rd_ready are both high.
  - On accept, latch ch, reg, write data and direction.
  - Write to TX on a mapped channel → WAIT_TX.
  - Read of RX data on a mapped channel → WAIT_RX.
  - Everything else → RD_FAST.
- RD_FAST (1 cycle): compute response, → RESP.
  - TX read returns zero-extended free count.
  - RX-present read returns {0, present}.
  - STATUS read returns {0, err_ie, rx_ie, sticky_to, tx_full, rx_present} in bits [4:0]; tx_full = (free == 0).
  - STATUS write: bit3 sets rx_ie, bit4 sets err_ie, bit2 = 1 clears sticky_to (write-1-to-clear).
  - Unmapped read returns 0; unmapped write and RX-data write are discarded and acked.
- WAIT_TX:
  - o_tx_valid[ch] = 1 with the latched byte.
  - On i_tx_ready[ch], drop valid and go to RESP.
- WAIT_RX:
  - o_rx_ready[ch] = 1.
  - On i_rx_valid[ch], capture i_rx_data into the response and go to RESP.
- Timeout (both wait states):
  - The counter increments each wait cycle.
  - When the count reaches TIMEOUT_CYCLES-1 with no handshake: deassert channel strobes, set sticky_to[ch], pulse o_timeout.
  - Read response becomes 0x100 (bit8 = no-data flag); the write is dropped but still acked.
  - Then → RESP.
  - A handshake on the final cycle wins over the timeout.
- RESP (1 cycle): o_mmio_rd_valid = 1 with o_mmio_data for reads, or o_mmio_wr_ready = 1 for writes; → GAP.
- GAP (1 cycle): ignores requests so a held request is not double-served; → IDLE.
- Latency: fast read/write responds 2 cycles after accept; minimum spacing between transactions is 4 cycles.
- At most one channel strobe is high at any time.
- o_tx_data holds the last byte sent (don't-care when valid is low).
- Request removal mid-transaction is ignored; the latched transaction completes.
- Reset mid-transaction aborts immediately; strobes drop asynchronously.

Test Plan:
- Write 0x41 to 0xFF, i_tx_ready[0] high after 3 cycles → o_tx_valid[0] high 3 cycles with o_tx_data[7:0] = 0x41, then o_mmio_wr_ready pulses once 1 cycle after the handshake.
- Read 0xFA (ch1 RX), i_rx_valid[1] with 0x5A 5 cycles later → o_rx_ready[1] high until then, o_mmio_rd_valid pulse with data 0x5A.
- Read 0xFE with no RX, TIMEOUT_CYCLES = 16 → o_timeout pulse after 16 wait cycles, response 0x100, STATUS at 0xFC reads 0x04; writing 0x04 to 0xFC clears it → reads 0x00.
- Write 0x08 to 0xF8 (ch1 STATUS), drive i_rx_present[1] = 1 → o_irq = 1; clear rx_present → o_irq = 0.
- NUM_CH = 2, read 0xF3 (ch3, unmapped) → data 0 after 2 cycles; simultaneous write to 0xFF and read → write served first, read served after GAP.
- Assert i_rst during WAIT_TX → o_tx_valid drops asynchronously, no ack issued, next access behaves as from reset.
